// File: rtl/btn_cmd_scheduler.sv
// Turns debounced button levels into prioritised pet-core commands issued over
// a valid/ready handshake, with a mandatory idle gap after each accepted command.
module btn_cmd_scheduler #(
  parameter int unsigned LONG_PRESS_CYCLES = 250000000,
  parameter int unsigned MIN_GAP_CYCLES    = 50000,
  parameter int unsigned CNT_W             = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_salud,
  input  logic       btn_hambre,
  input  logic       btn_reset,
  input  logic       btn_test,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic       test_mode,
  output logic       busy
);

  localparam int unsigned CODE_W = 3;
  localparam logic [CODE_W-1:0] CODE_NONE   = CODE_W'(0);
  localparam logic [CODE_W-1:0] CODE_RESET  = CODE_W'(1);
  localparam logic [CODE_W-1:0] CODE_TEST   = CODE_W'(2);
  localparam logic [CODE_W-1:0] CODE_SALUD  = CODE_W'(3);
  localparam logic [CODE_W-1:0] CODE_HAMBRE = CODE_W'(4);

  localparam logic [CNT_W-1:0] LP_LAST  = CNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_ARM   = CNT_W'(LONG_PRESS_CYCLES - 2);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((MIN_GAP_CYCLES > 0) ? MIN_GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   gap_cnt, gap_cnt_next;
  logic [CNT_W-1:0]   cnt_reset, cnt_test;
  logic               salud_lvl, salud_prev, hambre_lvl, hambre_prev;
  logic               pend_reset, pend_test, pend_salud, pend_hambre;
  logic               rise_salud, rise_hambre, set_reset, set_test;
  logic               hs, hs_reset, hs_test, hs_salud, hs_hambre;
  logic               any_pend;
  logic [CODE_W-1:0]  prio_code;
  logic               cmd_valid_d, busy_d;
  logic [CODE_W-1:0]  cmd_code_d;

  // Short-press edge detect: sampled level plus its previous value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      salud_lvl   <= 1'b0;
      salud_prev  <= 1'b0;
      hambre_lvl  <= 1'b0;
      hambre_prev <= 1'b0;
    end else begin
      salud_lvl   <= btn_salud;
      salud_prev  <= salud_lvl;
      hambre_lvl  <= btn_hambre;
      hambre_prev <= hambre_lvl;
    end
  end

  assign rise_salud  = salud_lvl & ~salud_prev;
  assign rise_hambre = hambre_lvl & ~hambre_prev;

  // Long-press qualifiers fire once, on the edge the counter saturates
  assign set_reset = btn_reset & (cnt_reset == LP_ARM);
  assign set_test  = btn_test  & (cnt_test  == LP_ARM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reset <= '0;
      cnt_test  <= '0;
    end else begin
      if (!btn_reset)              cnt_reset <= '0;
      else if (cnt_reset != LP_LAST) cnt_reset <= cnt_reset + CNT_W'(1);
      if (!btn_test)               cnt_test <= '0;
      else if (cnt_test != LP_LAST)  cnt_test <= cnt_test + CNT_W'(1);
    end
  end

  assign hs        = cmd_valid & cmd_ready;
  assign hs_reset  = hs & (cmd_code == CODE_RESET);
  assign hs_test   = hs & (cmd_code == CODE_TEST);
  assign hs_salud  = hs & (cmd_code == CODE_SALUD);
  assign hs_hambre = hs & (cmd_code == CODE_HAMBRE);

  // Pending flags: a set on the same edge as a clear is kept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_reset  <= 1'b0;
      pend_test   <= 1'b0;
      pend_salud  <= 1'b0;
      pend_hambre <= 1'b0;
      test_mode   <= 1'b0;
    end else begin
      pend_reset  <= set_reset   | (pend_reset  & ~hs_reset);
      pend_test   <= set_test    | (pend_test   & ~(hs_reset | hs_test));
      pend_salud  <= rise_salud  | (pend_salud  & ~(hs_reset | hs_salud));
      pend_hambre <= rise_hambre | (pend_hambre & ~(hs_reset | hs_hambre));
      if (hs_reset)     test_mode <= 1'b0;
      else if (hs_test) test_mode <= ~test_mode;
    end
  end

  assign any_pend = pend_reset | pend_test | pend_salud | pend_hambre;

  always_comb begin
    prio_code = CODE_NONE;
    if (pend_reset)       prio_code = CODE_RESET;
    else if (pend_test)   prio_code = CODE_TEST;
    else if (pend_salud)  prio_code = CODE_SALUD;
    else if (pend_hambre) prio_code = CODE_HAMBRE;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_next;
      gap_cnt <= gap_cnt_next;
    end
  end

  // FSM next state
  always_comb begin
    state_next   = state;
    gap_cnt_next = gap_cnt;
    case (state)
      S_IDLE: if (any_pend) state_next = S_ISSUE;
      S_ISSUE: begin
        if (hs) begin
          state_next   = (MIN_GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          gap_cnt_next = '0;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_next = S_IDLE;
        else                     gap_cnt_next = gap_cnt + CNT_W'(1);
      end
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs: code is latched on entry to ISSUE and frozen until accepted
  always_comb begin
    cmd_valid_d = 1'b0;
    cmd_code_d  = CODE_NONE;
    busy_d      = (state_next != S_IDLE);
    case (state)
      S_IDLE: begin
        if (any_pend) begin
          cmd_valid_d = 1'b1;
          cmd_code_d  = prio_code;
        end
      end
      S_ISSUE: begin
        if (!hs) begin
          cmd_valid_d = 1'b1;
          cmd_code_d  = cmd_code;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid <= 1'b0;
      cmd_code  <= CODE_NONE;
      busy      <= 1'b0;
    end else begin
      cmd_valid <= cmd_valid_d;
      cmd_code  <= cmd_code_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_btn_cmd_scheduler.sv
// Scoreboard bench for btn_cmd_scheduler: expected codes queued with stimulus,
// accepted commands captured at each handshake and compared in order.
module tb_btn_cmd_scheduler;

  logic       clk, rst;
  logic       btn_salud, btn_hambre, btn_reset, btn_test, cmd_ready;
  logic       cmd_valid, test_mode, busy;
  logic [2:0] cmd_code;

  int errors = 0;
  int checks = 0;
  logic [2:0] exp_q[$];
  logic [2:0] got_q[$];

  btn_cmd_scheduler #(
    .LONG_PRESS_CYCLES(8),
    .MIN_GAP_CYCLES   (4),
    .CNT_W            (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_salud (btn_salud),
    .btn_hambre(btn_hambre),
    .btn_reset (btn_reset),
    .btn_test  (btn_test),
    .cmd_ready (cmd_ready),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .test_mode (test_mode),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every accepted command
  always @(posedge clk) if (cmd_valid && cmd_ready) got_q.push_back(cmd_code);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_valid(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      tick();
      ok = cmd_valid;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_ready = 1'b1;
    btn_salud = 1'b1; btn_hambre = 1'b1; btn_reset = 1'b1; btn_test = 1'b1;
    settle(3);
    checks++;
    if ({cmd_valid, cmd_code, test_mode, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=000000", {cmd_valid, cmd_code, test_mode, busy});
    end
    rst = 1'b0; btn_salud = 1'b0; btn_hambre = 1'b0; btn_test = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      checks++;
      if (cmd_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_early_valid edge=%0d got=%b exp=0", i, cmd_valid);
      end
    end
    exp_q.push_back(3'd1);
    tick();
    checks++;
    if (cmd_valid !== 1'b1 || cmd_code !== 3'd1) begin
      errors++;
      $display("FAIL reset_issue valid=%b code=%0d exp valid=1 code=1", cmd_valid, cmd_code);
    end
    btn_reset = 1'b0;
    settle(10);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL reset_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [2:0] e, g;
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL reset_code got=%0d exp=%0d", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_heal();
    btn_salud = 1'b1;
    exp_q.push_back(3'd3);
    settle(2);
    checks++;
    if (cmd_valid !== 1'b0) begin errors++; $display("FAIL heal_k1 got=%b exp=0", cmd_valid); end
    tick();
    checks++;
    if (cmd_valid !== 1'b1 || cmd_code !== 3'd3) begin
      errors++;
      $display("FAIL heal_k2 valid=%b code=%0d exp valid=1 code=3", cmd_valid, cmd_code);
    end
    for (int i = 3; i <= 6; i++) begin
      tick();
      checks++;
      if (cmd_valid !== 1'b0 || cmd_code !== 3'd0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL heal_gap k+%0d valid=%b code=%0d busy=%b exp 0 0 1", i, cmd_valid, cmd_code, busy);
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL heal_idle busy got=%b exp=0", busy); end
    settle(3);
    btn_salud = 1'b0;
    settle(10);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL heal_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [2:0] e, g;
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL heal_code got=%0d exp=%0d", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_short_reset();
    btn_reset = 1'b1;
    settle(5);
    btn_reset = 1'b0;
    settle(15);
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL short_reset_none got=%0d exp=0", got_q.size());
    end
    got_q.delete();
    btn_reset = 1'b1;
    exp_q.push_back(3'd1);
    settle(7);
    checks++;
    if (cmd_valid !== 1'b0) begin errors++; $display("FAIL long_reset_early got=%b exp=0", cmd_valid); end
    tick();
    checks++;
    if (cmd_valid !== 1'b1 || cmd_code !== 3'd1) begin
      errors++;
      $display("FAIL long_reset_issue valid=%b code=%0d exp valid=1 code=1", cmd_valid, cmd_code);
    end
    settle(12);
    btn_reset = 1'b0;
    settle(10);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL long_reset_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [2:0] e, g;
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL long_reset_code got=%0d exp=%0d", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_simultaneous();
    cmd_ready = 1'b0;
    btn_salud = 1'b1; btn_hambre = 1'b1;
    exp_q.push_back(3'd3); exp_q.push_back(3'd4);
    tick();
    btn_salud = 1'b0; btn_hambre = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (cmd_valid !== 1'b1 || cmd_code !== 3'd3) begin
        errors++;
        $display("FAIL simul_hold cyc=%0d valid=%b code=%0d exp valid=1 code=3", i, cmd_valid, cmd_code);
      end
    end
    cmd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (cmd_valid !== 1'b0) begin errors++; $display("FAIL simul_gap cyc=%0d got=%b exp=0", i, cmd_valid); end
    end
    tick();
    checks++;
    if (cmd_valid !== 1'b1 || cmd_code !== 3'd4) begin
      errors++;
      $display("FAIL simul_second valid=%b code=%0d exp valid=1 code=4", cmd_valid, cmd_code);
    end
    settle(10);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL simul_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [2:0] e, g;
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL simul_code got=%0d exp=%0d", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_priority();
    bit ok;
    cmd_ready = 1'b0;
    btn_hambre = 1'b1;
    exp_q.push_back(3'd4); exp_q.push_back(3'd2); exp_q.push_back(3'd2);
    tick();
    btn_hambre = 1'b0;
    settle(2);
    btn_test = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (cmd_valid !== 1'b1 || cmd_code !== 3'd4) begin
        errors++;
        $display("FAIL prio_frozen cyc=%0d valid=%b code=%0d exp valid=1 code=4", i, cmd_valid, cmd_code);
      end
      tick();
    end
    btn_test = 1'b0;
    cmd_ready = 1'b1;
    tick();
    wait_valid(20, ok);
    checks++;
    if (!ok || cmd_code !== 3'd2 || test_mode !== 1'b0) begin
      errors++;
      $display("FAIL prio_test_issue ok=%b code=%0d tm=%b exp ok=1 code=2 tm=0", ok, cmd_code, test_mode);
    end
    tick();
    checks++;
    if (test_mode !== 1'b1) begin errors++; $display("FAIL prio_tm_set got=%b exp=1", test_mode); end
    settle(8);
    cmd_ready = 1'b0;
    btn_test = 1'b1;
    settle(10);
    btn_test = 1'b0;
    wait_valid(20, ok);
    checks++;
    if (!ok || cmd_code !== 3'd2 || test_mode !== 1'b1) begin
      errors++;
      $display("FAIL prio_test2_issue ok=%b code=%0d tm=%b exp ok=1 code=2 tm=1", ok, cmd_code, test_mode);
    end
    cmd_ready = 1'b1;
    tick();
    checks++;
    if (test_mode !== 1'b0) begin errors++; $display("FAIL prio_tm_clear got=%b exp=0", test_mode); end
    settle(10);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL prio_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [2:0] e, g;
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL prio_code got=%0d exp=%0d", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_clears();
    bit ok;
    cmd_ready = 1'b0;
    btn_test = 1'b1;
    exp_q.push_back(3'd2); exp_q.push_back(3'd1);
    settle(10);
    btn_test = 1'b0;
    wait_valid(20, ok);
    cmd_ready = 1'b1;
    tick();
    checks++;
    if (!ok || test_mode !== 1'b1) begin
      errors++;
      $display("FAIL clr_tm_pre ok=%b tm=%b exp ok=1 tm=1", ok, test_mode);
    end
    settle(8);
    cmd_ready = 1'b0;
    btn_reset = 1'b1;
    wait_valid(20, ok);
    checks++;
    if (!ok || cmd_code !== 3'd1) begin
      errors++;
      $display("FAIL clr_reset_issue ok=%b code=%0d exp ok=1 code=1", ok, cmd_code);
    end
    btn_salud = 1'b1;
    tick();
    btn_salud = 1'b0;
    settle(3);
    cmd_ready = 1'b1;
    tick();
    checks++;
    if (test_mode !== 1'b0) begin errors++; $display("FAIL clr_tm_post got=%b exp=0", test_mode); end
    btn_reset = 1'b0;
    settle(15);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL clr_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [2:0] e, g;
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL clr_code got=%0d exp=%0d", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    test_reset();
    test_heal();
    test_short_reset();
    test_simultaneous();
    test_priority();
    test_reset_clears();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
